// File: rtl/mod_mult_pipe.sv
// Multi-lane pipelined Barrett modular multiplier with valid/ready flow control.
// One mod_mult_lane per lane carries the datapath; valid/op/tag control is shared.

module mod_mult_lane #(
    parameter int              WIDTH       = 32,
    parameter longint unsigned Q           = 8380417,
    parameter int              K_BARRETT   = 23,
    parameter longint unsigned MU          = 8396807,
    parameter int              MULT_STAGES = 3
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             red_only,
    input  logic             neg,
    output logic [WIDTH-1:0] res,
    output logic             err
);
    localparam int LAT = MULT_STAGES + 2;
    localparam int PW  = 2 * WIDTH;
    localparam int RW  = K_BARRETT + 2;
    localparam int EW  = PW + K_BARRETT + 2;
    localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);
    localparam logic [RW-1:0]    Q_R = RW'(Q);

    logic [PW-1:0]    p_in;
    logic             err_in;
    logic [PW-1:0]    p_q [MULT_STAGES];
    logic             err_q [LAT];
    logic [EW-1:0]    est;
    logic [RW-1:0]    qhat, r_d, r_q, r1, r2;
    logic [WIDTH-1:0] res_d, res_q;

    // Reduce-only mode feeds a straight through; only its upper range is illegal.
    always_comb begin
        p_in   = PW'(a);
        err_in = |(PW'(a) >> (2 * K_BARRETT));
        if (!red_only) begin
            p_in   = PW'(a) * PW'(b);
            err_in = (a >= Q_W) || (b >= Q_W);
        end
    end

    // r only needs K_BARRETT+2 bits: Barrett leaves it below 3Q, so wrap is harmless.
    always_comb begin
        est  = EW'(p_q[MULT_STAGES-1] >> (K_BARRETT - 1)) * EW'(MU);
        qhat = RW'(est >> (K_BARRETT + 1));
        r_d  = RW'(p_q[MULT_STAGES-1]) - qhat * Q_R;
    end

    always_comb begin
        r1 = (r_q >= Q_R) ? r_q - Q_R : r_q;
        r2 = (r1 >= Q_R) ? r1 - Q_R : r1;
        if (neg && (r2 != '0))
            r2 = Q_R - r2;
        res_d = WIDTH'(r2);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            p_q[0]   <= p_in;
            err_q[0] <= err_in;
            for (int k = 1; k < MULT_STAGES; k++) p_q[k] <= p_q[k-1];
            for (int k = 1; k < LAT; k++) err_q[k] <= err_q[k-1];
            r_q   <= r_d;
            res_q <= res_d;
        end
    end

    assign res = res_q;
    assign err = err_q[LAT-1];
endmodule

module mod_mult_pipe #(
    parameter int              WIDTH       = 32,
    parameter int              LANES       = 2,
    parameter longint unsigned Q           = 8380417,
    parameter int              K_BARRETT   = 23,
    parameter longint unsigned MU          = 8396807,
    parameter int              MULT_STAGES = 3,
    parameter int              TAG_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [LANES-1:0]       out_err
);
    localparam int LAT = MULT_STAGES + 2;

    typedef struct packed {
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } ctl_t;

    logic                        adv;
    logic [LAT:1]                vld_pipe;
    ctl_t                        ctl_q [1:LAT];
    logic [LANES-1:0][WIDTH-1:0] a_l, b_l, res_l;
    logic                        red_only, neg;

    // One global enable: the whole pipe, bubbles included, moves or holds together.
    assign adv      = !vld_pipe[LAT] || out_ready;
    // Reset flushes everything anyway, so advertising ready during it is safe.
    assign in_ready = adv || rst;

    assign a_l      = in_a;
    assign b_l      = in_b;
    assign red_only = (in_op == 2'b10);
    assign neg      = (ctl_q[MULT_STAGES+1].op == 2'b01);

    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (adv)
            vld_pipe <= {vld_pipe[LAT-1:1], in_valid};
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            ctl_q[1] <= {in_op, in_tag};
            for (int k = 2; k <= LAT; k++) ctl_q[k] <= ctl_q[k-1];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mod_mult_lane #(
            .WIDTH(WIDTH), .Q(Q), .K_BARRETT(K_BARRETT), .MU(MU), .MULT_STAGES(MULT_STAGES)
        ) u_lane (
            .clk(clk), .en(adv), .a(a_l[i]), .b(b_l[i]),
            .red_only(red_only), .neg(neg), .res(res_l[i]), .err(out_err[i])
        );
    end

    assign out_valid  = vld_pipe[LAT];
    assign out_result = res_l;
    assign out_tag    = ctl_q[LAT].tag;
endmodule

// File: tb/tb_mod_mult_pipe.sv
// Directed + randomized bench for mod_mult_pipe against an arithmetic reference model.
module tb_mod_mult_pipe;
    localparam int              WIDTH = 32;
    localparam int              LANES = 2;
    localparam int              TAG_W = 8;
    localparam int              MS    = 3;
    localparam int              LAT   = MS + 2;
    localparam longint unsigned Q     = 8380417;
    localparam int              OW    = LANES*WIDTH + TAG_W + LANES;

    logic                   clk = 1'b0;
    logic                   rst, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]             in_op;
    logic [LANES*WIDTH-1:0] in_a, in_b, out_result;
    logic [TAG_W-1:0]       in_tag, out_tag;
    logic [LANES-1:0]       out_err;

    mod_mult_pipe #(
        .WIDTH(WIDTH), .LANES(LANES), .Q(Q), .K_BARRETT(23), .MU(8396807),
        .MULT_STAGES(MS), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES*WIDTH-1:0] res;
        logic [LANES*WIDTH-1:0] mask;
        logic [TAG_W-1:0]       tag;
        logic [LANES-1:0]       err;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        last_obs;
    int           n_total = 0, n_pass = 0;
    bit           popped, accepted, prev_stall = 1'b0;
    logic [OW-1:0] prev_out;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [WIDTH-1:0] ref_lane(input longint unsigned a, b, input logic [1:0] op);
        longint unsigned m;
        if (op == 2'b10) return WIDTH'(a % Q);
        m = (a * b) % Q;
        if (op == 2'b01) return WIDTH'((m == 0) ? 0 : Q - m);
        return WIDTH'(m);
    endfunction

    function automatic beat_t model();
        beat_t e;
        longint unsigned a, b;
        e.tag = in_tag;
        for (int i = 0; i < LANES; i++) begin
            a = longint'(in_a[i*WIDTH +: WIDTH]);
            b = longint'(in_b[i*WIDTH +: WIDTH]);
            e.res[i*WIDTH +: WIDTH]  = ref_lane(a, b, in_op);
            e.err[i]                 = (in_op == 2'b10) ? (a >= (64'd1 << 46)) : (a >= Q || b >= Q);
            e.mask[i*WIDTH +: WIDTH] = e.err[i] ? '0 : '1;
        end
        return e;
    endfunction

    // Inputs are set at a negedge; sample #1 later, then advance to the next negedge.
    task automatic step();
        beat_t e;
        #1;
        popped   = 1'b0;
        accepted = 1'b0;
        if (rst) chk("rst_in_ready", in_ready, 1'b1);
        else begin
            chk("in_ready_adv", in_ready, !out_valid || out_ready);
            if (prev_stall) chk("stall_hold", {out_result, out_tag, out_err}, prev_out);
            if (in_valid && in_ready) begin
                exp_q.push_back(model());
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                popped       = 1'b1;
                last_obs.res = out_result;
                last_obs.tag = out_tag;
                last_obs.err = out_err;
                if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_res", out_result & e.mask, e.res & e.mask);
                    chk("sb_tag", out_tag, e.tag);
                    chk("sb_err", out_err, e.err);
                end
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_out   = {out_result, out_tag, out_err};
        @(negedge clk);
    endtask

    task automatic one(input string nm, input logic [31:0] a0, b0, a1, b1, input logic [1:0] op,
                       input logic [7:0] tag, input logic [31:0] r0, r1, input logic [1:0] err,
                       input bit chk1);
        int lat = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = {a1, a0}; in_b = {b1, b0}; in_op = op; in_tag = tag;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (popped) begin lat = k; break; end
        end
        chk({nm, "_lat"}, lat, LAT);
        chk({nm, "_r0"}, last_obs.res[31:0], r0);
        if (chk1) chk({nm, "_r1"}, last_obs.res[63:32], r1);
        chk({nm, "_tag"}, last_obs.tag, tag);
        chk({nm, "_err"}, last_obs.err, err);
    endtask

    task automatic rand_beat();
        in_a   = {32'($urandom_range(0, 32'(Q - 1))), 32'($urandom_range(0, 32'(Q - 1)))};
        in_b   = {32'($urandom_range(0, 32'(Q - 1))), 32'($urandom_range(0, 32'(Q - 1)))};
        in_op  = 2'($urandom_range(0, 3));
        in_tag = 8'($urandom);
    endtask

    initial begin
        int cnt, guard;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        rand_beat();
        @(negedge clk);
        // reset with in_valid high: nothing may emerge
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        for (int k = 0; k < LAT + 2; k++) begin
            chk("idle_out_valid", out_valid, 1'b0);
            step();
        end

        one("basic", 2, 3, 8380416, 8380416, 2'b00, 8'h5A, 6, 1, 2'b00, 1'b1);
        one("neg",   2, 3, 2, 3, 2'b01, 8'h11, 8380411, 8380411, 2'b00, 1'b1);
        one("negz",  0, 12345, 0, 0, 2'b01, 8'h22, 0, 0, 2'b00, 1'b1);
        one("big",   4194304, 2, 4194304, 2, 2'b00, 8'h33, 8191, 8191, 2'b00, 1'b1);
        one("red",   8380417, 99, 8380422, 7, 2'b10, 8'h44, 0, 5, 2'b00, 1'b1);
        one("op11",  2, 3, 8380416, 8380416, 2'b11, 8'h55, 6, 1, 2'b00, 1'b1);
        one("err",   2, 3, 8380417, 1, 2'b00, 8'h66, 6, 0, 2'b10, 1'b0);

        // random stream with pseudo-random backpressure
        cnt = 0; guard = 0;
        begin
            int sent = 0;
            while (cnt < 20 && guard < 1000) begin
                rand_beat();
                in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
                out_ready = 1'($urandom);
                step();
                if (accepted) sent++;
                if (popped) cnt++;
                guard++;
            end
        end
        chk("bp_count", cnt, 20);
        chk("bp_empty", exp_q.size(), 0);

        // fill with output blocked, then pop+push every cycle
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin rand_beat(); step(); end
        chk("fill_count", exp_q.size(), LAT);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rand_beat();
            step();
            chk("pp_both", {accepted, popped}, 2'b11);
            chk("pp_inflight", exp_q.size(), LAT);
        end
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 30) begin step(); guard++; end
        chk("drain", exp_q.size(), 0);

        // reset with three beats in flight
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin rand_beat(); step(); end
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid) cnt++;
        end
        chk("rst_flush", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
